overlay_sched: RTL and testbench
================================

# overlay_sched

Arbiter and prefetch sequencer for the overlay SDRAM channel. It shares the single ch1 port between two requesters. The first is the overlay file download, which packs bytes into 16-bit writes. The second is the display path, which streams 32-bit reads into a small FIFO and pops one 16-bit ABGR pixel per active pixel strobe. It sits between hps_io/video timing and the sdram controller, replacing ad-hoc request generation in the top level.

## Interface
Parameters:
- FIFO_DEPTH, 4: 32-bit entries in prefetch FIFO (power of two, ≥2)
- AW, 24: SDRAM word-address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  overlay in use; 0 forces pixel output to 0 and blocks reads
- dl_active  in  1  overlay download in progress
- dl_wr  in  1  download byte strobe
- dl_addr  in  25  download byte address
- dl_data  in  8  download byte
- ce_pix  in  1  pixel clock enable
- hblank, vblank  in  1  blanking; active video = ~(hblank|vblank)
- vsync  in  1  frame sync; rising edge restarts the frame
- pix_out  out  16  {a,b,g,r}, 4 bits each
- mem_addr  out  AW  word address
- mem_din  out  16  write data {odd byte, even byte}
- mem_rnw  out  1  1 = read
- mem_req  out  1  one-cycle request pulse
- mem_ack  in  1  one-cycle completion; mem_dout valid in this cycle for reads
- mem_dout  in  32  read data, low halfword = lower address
- dl_overrun  out  1  sticky: write pair lost
- underflow_cnt  out  16  present only with OVERLAY_SCHED_STATS_EN

## Operation
- Byte packing: a dl_wr with dl_addr[0]=0 latches the even byte. A dl_wr with dl_addr[0]=1 completes the pair and loads the write holding register with addr=dl_addr[24:1] and data {dl_data, even}. dl_wr is ignored unless dl_active.
- If the pair completes while the holding register is still pending, the pair is dropped and dl_overrun is set. dl_overrun clears only on reset.
- FSM states:
  - IDLE: if a write is pending, go to WR_WAIT (write has priority). Otherwise, if a read is allowed, go to RD_WAIT.
  - WR_WAIT: on mem_ack, clear pending and return to IDLE.
  - RD_WAIT: on mem_ack, push mem_dout unless the discard flag is set, then return to IDLE.
- A read is allowed when enable & ~dl_active & FIFO not full. At most one transaction is outstanding.
- Read address counter rd_addr increments by 2 per issued read. It wraps modulo 2^AW.
- Pop: on ce_pix during active video, pix_out is loaded with the current halfword (low first, then high). The entry is freed after its high half is taken. If the FIFO is empty, pix_out is 0 and an underflow event occurs.
- ce_pix outside active video holds pix_out.
- On a vsync rising edge (sampled every clk, not gated by ce_pix):
  - FIFO and half-select are flushed and rd_addr goes to 0.
  - If in RD_WAIT, the discard flag is set and that ack's data is dropped.
  - A pop coinciding with the edge is ignored.
  - A push coinciding with the edge is discarded.
- When enable=0 or dl_active=1: pix_out=0, the FIFO is flushed, and rd_addr=0.
- mem_ack in IDLE is ignored.

## Timing
- Reset: state IDLE, mem_req=0, mem_rnw=1, mem_addr=0, mem_din=0, pix_out=0, dl_overrun=0, FIFO empty, rd_addr=0, underflow_cnt=0.
- A mid-transaction reset abandons the transaction; the later ack is ignored.
- mem_req pulses in the cycle after the IDLE decision. mem_addr, mem_din and mem_rnw are valid in the mem_req cycle and held until mem_ack.
- Byte-pair completion to mem_req: 2 clk when the FSM is idle.
- Pixel latency: pix_out is updated the clk after ce_pix.
- A pushed word is poppable the clk after mem_ack.
- Push and pop in the same cycle are both honoured; the count is unchanged.
- Full-FIFO push cannot occur because a read is issued only with a free slot. This counts the outstanding read: issue only if count + outstanding < FIFO_DEPTH.
- Best-case read rate is one per 3 clk.

## Configuration
- OVERLAY_SCHED_STATS_EN defined:
  - underflow_cnt increments on each underflow pop and saturates at 16'hFFFF.
  - It clears on reset and on a vsync rising edge, after capturing the previous frame's count into the output register. underflow_cnt therefore shows the last complete frame.
- Not defined: the port is absent and there is no counter logic.

## Test plan
- Download write: dl_active=1, bytes 0x34@addr 0x10 then 0x12@0x11 → one mem_req with mem_rnw=0, mem_addr=0x8, mem_din=0x1234; dl_overrun=0.
- Overrun: hold mem_ack low and complete two pairs → second pair is dropped, dl_overrun=1, and only the first write is issued after ack.
- Prefetch: enable=1, ack reads with 0xBBBBAAAA, 0xDDDDCCCC → reads at addr 0, 2, 4, 6 until 4 entries are held; pops give 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD.
- Underflow: enable=1 with mem_ack never asserted, 3 active ce_pix → pix_out=0; with the macro defined, underflow_cnt=3 after the next vsync edge.
- Vsync flush: vsync rises while in RD_WAIT, ack returns 0xFFFFFFFF → data dropped, next mem_addr=0, first popped pixel comes from the addr-0 read.
- Reset mid-read: reset during RD_WAIT, then stray mem_ack → FSM stays IDLE, FIFO empty, all outputs at reset values.

Source files
------------

// File: rtl/overlay_sched.sv
// Overlay SDRAM channel arbiter: download byte packer plus display prefetch FIFO.
// Optional frame underflow counter: define OVERLAY_SCHED_STATS_EN.
module overlay_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          ce_pix,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          vsync,
  output logic [15:0]   pix_out,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic          mem_rnw,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [31:0]   mem_dout,
  output logic          dl_overrun
`ifdef OVERLAY_SCHED_STATS_EN
  ,
  output logic [15:0]   underflow_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_t;

  state_t        state;
  logic          vs_q;
  logic          vs_rise;
  logic          rd_off;
  logic          flush;
  logic          active;

  logic [7:0]    even_q;
  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          pair_done;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          half;
  logic [AW-1:0] rd_addr;
  logic          discard;

  logic          wr_ack;
  logic          rd_ack;
  logic          push;
  logic          pix_try;
  logic          pop_ok;
  logic          under;
  logic          free;
  logic          rd_ok;

  assign vs_rise   = vsync & ~vs_q;
  assign rd_off    = ~enable | dl_active;
  assign flush     = vs_rise | rd_off;
  assign active    = ~(hblank | vblank);
  assign pair_done = dl_active & dl_wr & dl_addr[0];

  assign wr_ack  = (state == WR_WAIT) & mem_ack;
  assign rd_ack  = (state == RD_WAIT) & mem_ack;
  assign push    = rd_ack & ~discard & ~flush;
  assign pix_try = ce_pix & active & ~flush;
  assign pop_ok  = pix_try & (cnt != '0);
  assign under   = pix_try & (cnt == '0);
  assign free    = pop_ok & half;
  // Only entered from IDLE, so nothing is outstanding at this point.
  assign rd_ok   = ~flush & (cnt < CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      even_q     <= '0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      dl_overrun <= 1'b0;
    end else begin
      if (dl_active & dl_wr & ~dl_addr[0])
        even_q <= dl_data;
      if (wr_ack)
        wr_pend <= 1'b0;
      if (pair_done) begin
        if (wr_pend) begin
          dl_overrun <= 1'b1;
        end else begin
          wr_pend <= 1'b1;
          wr_addr <= AW'(dl_addr[24:1]);
          wr_data <= {dl_data, even_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_rnw  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_addr  <= '0;
      discard  <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (flush)
        rd_addr <= '0;
      unique case (state)
        IDLE: begin
          discard <= 1'b0;
          if (wr_pend) begin
            state    <= WR_WAIT;
            mem_req  <= 1'b1;
            mem_rnw  <= 1'b0;
            mem_addr <= wr_addr;
            mem_din  <= wr_data;
          end else if (rd_ok) begin
            state    <= RD_WAIT;
            mem_req  <= 1'b1;
            mem_rnw  <= 1'b1;
            mem_addr <= rd_addr;
            rd_addr  <= rd_addr + AW'(2);
          end
        end
        WR_WAIT: begin
          if (mem_ack)
            state <= IDLE;
        end
        RD_WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wp] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      half    <= 1'b0;
      pix_out <= '0;
    end else begin
      if (flush) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        half <= 1'b0;
      end else begin
        if (push)
          wp <= wp + PW'(1);
        if (pop_ok) begin
          half <= ~half;
          if (half)
            rp <= rp + PW'(1);
        end
        cnt <= cnt + CW'(push) - CW'(free);
      end
      if (rd_off)
        pix_out <= '0;
      else if (pix_try)
        pix_out <= (cnt == '0) ? 16'h0000 :
                   half ? fifo_mem[rp][31:16] :
                          fifo_mem[rp][15:0];
    end
  end

`ifdef OVERLAY_SCHED_STATS_EN
  logic [15:0] ucur;

  always_ff @(posedge clk) begin
    if (reset) begin
      ucur          <= '0;
      underflow_cnt <= '0;
    end else if (vs_rise) begin
      underflow_cnt <= ucur;
      ucur          <= '0;
    end else if (under && ucur != 16'hFFFF) begin
      ucur <= ucur + 16'd1;
    end
  end
`else
  logic unused_under;
  assign unused_under = under;
`endif

endmodule

// File: tb/tb_overlay_sched.sv
// Directed bench for overlay_sched: download, overrun, prefetch,
// underflow, vsync flush and mid-read reset.
module tb_overlay_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        ce_pix;
  logic        hblank;
  logic        vblank;
  logic        vsync;
  logic [15:0] pix_out;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_rnw;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_dout;
  logic        dl_overrun;
`ifdef OVERLAY_SCHED_STATS_EN
  logic [15:0] underflow_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  overlay_sched #(.FIFO_DEPTH(4), .AW(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .ce_pix     (ce_pix),
    .hblank     (hblank),
    .vblank     (vblank),
    .vsync      (vsync),
    .pix_out    (pix_out),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_rnw    (mem_rnw),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_dout   (mem_dout),
    .dl_overrun (dl_overrun)
`ifdef OVERLAY_SCHED_STATS_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack  = 1'b1;
    mem_dout = d;
    tick();
    mem_ack  = 1'b0;
    mem_dout = '0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [15:0] exp);
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    chk(tag, 32'(pix_out), 32'(exp));
  endtask

  task automatic count_reqs(input string tag, input int cyc);
    int seen = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (mem_req) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  logic [31:0] rd_vals [4];

  initial begin
    rd_vals[0] = 32'hBBBBAAAA;
    rd_vals[1] = 32'hDDDDCCCC;
    rd_vals[2] = 32'h22221111;
    rd_vals[3] = 32'h44443333;

    reset = 1'b1; enable = 1'b0; dl_active = 1'b0;
    dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1; vsync = 1'b0;
    mem_ack = 1'b0; mem_dout = '0;
    repeat (3) tick();

    chk("rst_pix", 32'(pix_out), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_rnw", 32'(mem_rnw), 32'h1);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);
    chk("rst_ovr", 32'(dl_overrun), 32'h0);
`ifdef OVERLAY_SCHED_STATS_EN
    chk("rst_ucnt", 32'(underflow_cnt), 32'h0);
`endif
    reset = 1'b0;
    dl_active = 1'b1;
    tick();

    // download pair: request two clocks after completing byte
    wr_byte(25'h10, 8'h34);
    wr_byte(25'h11, 8'h12);
    tick();
    chk("dl_req", 32'(mem_req), 32'h1);
    chk("dl_rnw", 32'(mem_rnw), 32'h0);
    chk("dl_addr", 32'(mem_addr), 32'h8);
    chk("dl_din", 32'(mem_din), 32'h1234);
    chk("dl_ovr", 32'(dl_overrun), 32'h0);
    tick();
    chk("dl_pulse", 32'(mem_req), 32'h0);
    chk("dl_hold", 32'(mem_addr), 32'h8);
    ack(32'h0);

    // overrun: second pair lands while the first is pending
    wr_byte(25'h20, 8'h78);
    wr_byte(25'h21, 8'h56);
    wr_byte(25'h30, 8'hBC);
    wr_byte(25'h31, 8'h9A);
    chk("ovr_set", 32'(dl_overrun), 32'h1);
    chk("ovr_addr", 32'(mem_addr), 32'h10);
    chk("ovr_din", 32'(mem_din), 32'h5678);
    ack(32'h0);
    count_reqs("ovr_noreq", 10);

    // prefetch four entries
    dl_active = 1'b0;
    enable    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("pf_req%0d", k));
      chk($sformatf("pf_addr%0d", k), 32'(mem_addr), 32'(2 * k));
      chk($sformatf("pf_rnw%0d", k), 32'(mem_rnw), 32'h1);
      ack(rd_vals[k]);
    end
    count_reqs("pf_full", 10);

    hblank = 1'b0; vblank = 1'b0;
    pop("pop0", 16'hAAAA);
    pop("pop1", 16'hBBBB);
    pop("pop2", 16'hCCCC);
    pop("pop3", 16'hDDDD);
    hblank = 1'b1;
    pop("hold", 16'hDDDD);
    hblank = 1'b0;
    pop("pop4", 16'h1111);
    chk("ovr_sticky", 32'(dl_overrun), 32'h1);

    // vsync while a read (addr 8) is outstanding
    hblank = 1'b1;
    repeat (3) tick();
    chk("vs_pre_addr", 32'(mem_addr), 32'h8);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    ack(32'hFFFFFFFF);
    wait_req("vs_req");
    chk("vs_addr0", 32'(mem_addr), 32'h0);
    ack(32'h66665555);
    hblank = 1'b0;
    pop("vs_pop", 16'h5555);

    // underflow: flush, then never acknowledge
    hblank = 1'b1;
    vs_pulse();
    repeat (4) tick();
`ifdef OVERLAY_SCHED_STATS_EN
    chk("uf_prev", 32'(underflow_cnt), 32'h0);
`endif
    hblank = 1'b0;
    pop("uf0", 16'h0);
    pop("uf1", 16'h0);
    pop("uf2", 16'h0);
    hblank = 1'b1;
    vs_pulse();
`ifdef OVERLAY_SCHED_STATS_EN
    chk("uf_cnt", 32'(underflow_cnt), 32'h3);
`endif
    chk("uf_rdwait", 32'(mem_rnw), 32'h1);

    // reset during an outstanding read, then a stray ack
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    ack(32'h12345678);
    tick();
    chk("mr_req", 32'(mem_req), 32'h0);
    chk("mr_rnw", 32'(mem_rnw), 32'h1);
    chk("mr_addr", 32'(mem_addr), 32'h0);
    chk("mr_din", 32'(mem_din), 32'h0);
    chk("mr_pix", 32'(pix_out), 32'h0);
    chk("mr_ovr", 32'(dl_overrun), 32'h0);
    enable = 1'b1;
    hblank = 1'b0;
    pop("mr_empty", 16'h0);
    wait_req("mr_req2");
    chk("mr_addr2", 32'(mem_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
